// File: rtl/prefetcher_mon_pkg.sv
// prefetcher_mon_pkg: shared types, error bit positions and helpers for the AXI read latency monitor
//   tbl_entry_t : one outstanding-transaction slot (valid, id, issue timestamp, measured flag)
//   ERR_*       : bit positions inside errorCode
//   sat_inc     : counter increment that sticks at all-ones
package prefetcher_mon_pkg;

    localparam int TID_W = 8;
    localparam int TS_W  = 16;
    localparam int CNT_W = 32;

    localparam int ERR_OVERFLOW = 0;
    localparam int ERR_ORPHAN   = 1;
    localparam int ERR_SAT      = 2;

    typedef struct packed {
        logic             valid;
        logic [TID_W-1:0] id;
        logic [TS_W-1:0]  ts;
        logic             measured;
    } tbl_entry_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/latency_hist_bins.sv
// latency_hist_bins: bank of saturating latency histogram counters
//   clk, resetN : clock, async active-low reset
//   rec_i       : record strobe, lat_i : latency being recorded
//   clear_i     : synchronous clear of every bin (wins over rec_i)
//   bins_o      : flattened bins, bin 0 at LSBs
//   sat_o       : the recorded bin was already all-ones
module latency_hist_bins
    import prefetcher_mon_pkg::*;
#(
    parameter int TS_WIDTH     = TS_W,
    parameter int CNT_WIDTH    = CNT_W,
    parameter int LOG_NUM_BINS = 3,
    parameter int BIN_SHIFT    = 2
) (
    input  logic                                 clk,
    input  logic                                 resetN,
    input  logic                                 rec_i,
    input  logic [TS_WIDTH-1:0]                  lat_i,
    input  logic                                 clear_i,
    output logic [(1<<LOG_NUM_BINS)*CNT_WIDTH-1:0] bins_o,
    output logic                                 sat_o
);

    localparam int NB = 1 << LOG_NUM_BINS;

    logic [CNT_WIDTH-1:0]    bin_q [NB];
    logic [TS_WIDTH-1:0]     shifted;
    logic [LOG_NUM_BINS-1:0] idx;

    // latencies beyond the last bin are clamped into it
    assign shifted = lat_i >> BIN_SHIFT;
    assign idx     = (shifted > TS_WIDTH'(NB - 1)) ? LOG_NUM_BINS'(NB - 1) : shifted[LOG_NUM_BINS-1:0];
    assign sat_o   = rec_i & (&bin_q[idx]);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NB; i++) bin_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NB; i++) bin_q[i] <= '0;
        end else if (rec_i) begin
            bin_q[idx] <= sat_inc(bin_q[idx]);
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_flat
        assign bins_o[b*CNT_WIDTH +: CNT_WIDTH] = bin_q[b];
    end

endmodule

// File: rtl/axi_rd_latency_monitor.sv
// axi_rd_latency_monitor: passive AXI read monitor measuring per-transaction latency
//   clk, resetN           : clock, async active-low reset
//   en                    : allow new AR allocations (R matching always continues)
//   clear                 : synchronous clear of statistics and errors, table untouched
//   crs_measureFirst      : 1 = measure at first R beat, 0 = at last R beat
//   ar_* / r_*            : snooped AR and R handshakes
//   stat_*                : count, sum, min, max of recorded latencies, outstanding entries
//   hist_bins             : flattened latency histogram, bin 0 at LSBs
//   errorCode             : sticky {saturation, orphan R, table overflow}
module axi_rd_latency_monitor
    import prefetcher_mon_pkg::*;
#(
    parameter int TID_WIDTH      = TID_W,
    parameter int LOG_TABLE_SIZE = 3,
    parameter int TS_WIDTH       = TS_W,
    parameter int SUM_WIDTH      = 40,
    parameter int CNT_WIDTH      = CNT_W,
    parameter int LOG_NUM_BINS   = 3,
    parameter int BIN_SHIFT      = 2
) (
    input  logic                                   clk,
    input  logic                                   resetN,
    input  logic                                   en,
    input  logic                                   clear,
    input  logic                                   crs_measureFirst,
    input  logic                                   ar_valid,
    input  logic                                   ar_ready,
    input  logic [TID_WIDTH-1:0]                   ar_id,
    input  logic                                   r_valid,
    input  logic                                   r_ready,
    input  logic                                   r_last,
    input  logic [TID_WIDTH-1:0]                   r_id,
    output logic [CNT_WIDTH-1:0]                   stat_count,
    output logic [SUM_WIDTH-1:0]                   stat_sum,
    output logic [TS_WIDTH-1:0]                    stat_min,
    output logic [TS_WIDTH-1:0]                    stat_max,
    output logic [LOG_TABLE_SIZE:0]                stat_outstanding,
    output logic [(1<<LOG_NUM_BINS)*CNT_WIDTH-1:0] hist_bins,
    output logic [2:0]                             errorCode
);

    localparam int N = 1 << LOG_TABLE_SIZE;

    logic [TS_WIDTH-1:0]       ts_q;
    tbl_entry_t                tbl_q [N];
    tbl_entry_t                tbl_d [N];
    logic [LOG_TABLE_SIZE:0]   outst_q, outst_d;
    logic [CNT_WIDTH-1:0]      count_q, count_d;
    logic [SUM_WIDTH-1:0]      sum_q, sum_d;
    logic [TS_WIDTH-1:0]       min_q, min_d, max_q, max_d;
    logic [2:0]                err_q, err_d, err_set;
    logic                      ar_hs, r_hs, alloc_ok, hit, rec, hist_sat;
    logic [LOG_TABLE_SIZE-1:0] alloc_idx, hit_idx;
    logic [TS_WIDTH-1:0]       hit_lat;
    logic [SUM_WIDTH:0]        sum_add;

    always_comb begin
        ar_hs     = ar_valid & ar_ready & en;
        r_hs      = r_valid & r_ready;
        tbl_d     = tbl_q;
        alloc_ok  = 1'b0;
        alloc_idx = '0;
        hit       = 1'b0;
        hit_idx   = '0;
        hit_lat   = '0;
        // descending scan so the lowest free index is the one left standing
        for (int i = N - 1; i >= 0; i--) begin
            if (!tbl_q[i].valid) begin
                alloc_ok  = 1'b1;
                alloc_idx = i[LOG_TABLE_SIZE-1:0];
            end
        end
        // oldest same-ID entry is the one with the largest age
        for (int i = 0; i < N; i++) begin
            if (tbl_q[i].valid && tbl_q[i].id == r_id && (!hit || (ts_q - tbl_q[i].ts) > hit_lat)) begin
                hit     = 1'b1;
                hit_idx = i[LOG_TABLE_SIZE-1:0];
                hit_lat = ts_q - tbl_q[i].ts;
            end
        end
        rec = r_hs & hit & ~tbl_q[hit_idx].measured & (crs_measureFirst | r_last);
        if (rec) tbl_d[hit_idx].measured = 1'b1;
        if (r_hs && hit && r_last) tbl_d[hit_idx].valid = 1'b0;
        // allocation only ever targets an entry free before this cycle, so it never collides with the R update
        if (ar_hs && alloc_ok) tbl_d[alloc_idx] = '{valid: 1'b1, id: ar_id, ts: ts_q, measured: 1'b0};
        outst_d = '0;
        for (int i = 0; i < N; i++) outst_d = outst_d + {{LOG_TABLE_SIZE{1'b0}}, tbl_d[i].valid};
        sum_add = {1'b0, sum_q} + {{(SUM_WIDTH + 1 - TS_WIDTH){1'b0}}, hit_lat};
        err_set                = '0;
        err_set[ERR_OVERFLOW] = ar_hs & ~alloc_ok;
        err_set[ERR_ORPHAN]   = r_hs & ~hit;
        err_set[ERR_SAT]      = rec & ((&count_q) | sum_add[SUM_WIDTH] | hist_sat);
        count_d = clear ? '0 : rec ? sat_inc(count_q) : count_q;
        sum_d   = clear ? '0 : rec ? (sum_add[SUM_WIDTH] ? '1 : sum_add[SUM_WIDTH-1:0]) : sum_q;
        min_d   = clear ? '1 : (rec && hit_lat < min_q) ? hit_lat : min_q;
        max_d   = clear ? '0 : (rec && hit_lat > max_q) ? hit_lat : max_q;
        err_d   = clear ? '0 : err_q | err_set;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ts_q    <= '0;
            outst_q <= '0;
            count_q <= '0;
            sum_q   <= '0;
            min_q   <= '1;
            max_q   <= '0;
            err_q   <= '0;
            for (int i = 0; i < N; i++) tbl_q[i] <= '0;
        end else begin
            ts_q    <= ts_q + 1'b1;
            outst_q <= outst_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            err_q   <= err_d;
            tbl_q   <= tbl_d;
        end
    end

    latency_hist_bins #(
        .TS_WIDTH    (TS_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH),
        .LOG_NUM_BINS(LOG_NUM_BINS),
        .BIN_SHIFT   (BIN_SHIFT)
    ) u_bins (
        .clk    (clk),
        .resetN (resetN),
        .rec_i  (rec),
        .lat_i  (hit_lat),
        .clear_i(clear),
        .bins_o (hist_bins),
        .sat_o  (hist_sat)
    );

    assign stat_count       = count_q;
    assign stat_sum         = sum_q;
    assign stat_min         = min_q;
    assign stat_max         = max_q;
    assign stat_outstanding = outst_q;
    assign errorCode        = err_q;

endmodule
